match_link_rx_framer: RTL and testbench

- Frames the inter-sector residual link stream, one BX at a time, and feeds the match-memory write-enable decoder.
- Pops 48-bit link words from the receive FIFO, strips BX headers, and presents 45-bit residual words with a valid strobe on data_residuals/valid.
- Reports frame boundaries on output_BX/send_BX and flags sequence, truncation, overflow and orphan errors.

---
 rtl/match_link_rx_framer.sv | 219 +++++++++++++++++++++
 tb/tb_match_link_rx_framer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/match_link_rx_framer.sv
// Residual link framer: pops 48-bit link words, strips BX headers and forwards
// 45-bit residuals per BX frame, reporting frame closes and link errors.
module match_link_rx_framer #(
   parameter int MAX_WORDS = 64,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [47:0]      fifo_dout,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic             hold,
   output logic [44:0]      data_residuals,
   output logic             valid,
   output logic [3:0]       output_BX,
   output logic             send_BX,
   output logic             err_bx_seq,
   output logic             err_trunc,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] orphan_cnt
);

   typedef enum logic [1:0] {
      WAIT_HDR = 2'd0,
      STREAM   = 2'd1,
      CLOSE    = 2'd2
   } state_t;

   // Word counter is 8 bits (N <= 255), so clamp the limit into the 9-bit compare range.
   localparam int          MAX_CL = (MAX_WORDS > 255) ? 256 : MAX_WORDS;
   localparam logic [8:0]  MAX_W9 = 9'(MAX_CL);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_t           state_q, state_d;
   logic             first_q, first_d;
   logic [3:0]       bx_q, bx_d;
   logic [3:0]       prev_bx_q, prev_bx_d;
   logic [7:0]       n_q, n_d;
   logic [7:0]       wc_q, wc_d;
   logic             rd_q, rd_d;
   logic             pend_q, pend_d;
   logic [47:0]      pend_word_q, pend_word_d;
   logic [44:0]      data_q, data_d;
   logic             valid_q, valid_d;
   logic [3:0]       obx_q, obx_d;
   logic             send_q, send_d;
   logic             seq_q, seq_d;
   logic             trunc_q, trunc_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [CNT_W-1:0] orphan_q, orphan_d;

   logic [47:0]      in_word_s;
   logic             in_vld_s;
   logic             hdr_accept_s;
   logic [3:0]       chk_bx_s;
   logic [3:0]       exp_bx_s;

   // No pop while closing; a word already in flight is parked in pend_word_q.
   assign fifo_rd_en = reset & ~fifo_empty & ~hold & (state_q != CLOSE);
   assign rd_d       = fifo_rd_en;
   assign in_word_s  = pend_q ? pend_word_q : fifo_dout;
   assign in_vld_s   = (pend_q | rd_q) & (state_q != CLOSE);

   assign data_residuals = data_q;
   assign valid          = valid_q;
   assign output_BX      = obx_q;
   assign send_BX        = send_q;
   assign err_bx_seq     = seq_q;
   assign err_trunc      = trunc_q;
   assign drop_cnt       = drop_q;
   assign orphan_cnt     = orphan_q;

   // Next-state and registered-output decode of the current link word.
   always_comb begin
      state_d      = state_q;
      first_d      = first_q;
      bx_d         = bx_q;
      prev_bx_d    = prev_bx_q;
      n_d          = n_q;
      wc_d         = wc_q;
      pend_d       = pend_q;
      pend_word_d  = pend_word_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      obx_d        = obx_q;
      send_d       = 1'b0;
      seq_d        = 1'b0;
      trunc_d      = 1'b0;
      drop_d       = drop_q;
      orphan_d     = orphan_q;
      hdr_accept_s = 1'b0;
      chk_bx_s     = prev_bx_q;
      exp_bx_s     = 4'd0;

      case (state_q)
         WAIT_HDR: begin
            if (in_vld_s) begin
               pend_d = 1'b0;
               if (in_word_s[47]) begin
                  hdr_accept_s = 1'b1;
               end else begin
                  orphan_d = sat_inc(orphan_q);
               end
            end else begin
               pend_d = pend_q;
            end
         end
         STREAM: begin
            if (in_vld_s) begin
               pend_d = 1'b0;
               if (in_word_s[47]) begin
                  // Header mid-frame: close the old frame and open the new one together.
                  trunc_d      = 1'b1;
                  send_d       = 1'b1;
                  obx_d        = bx_q;
                  prev_bx_d    = bx_q;
                  chk_bx_s     = bx_q;
                  hdr_accept_s = 1'b1;
               end else begin
                  if ({1'b0, wc_q} < MAX_W9) begin
                     valid_d = 1'b1;
                     data_d  = in_word_s[44:0];
                  end else begin
                     drop_d = sat_inc(drop_q);
                  end
                  wc_d = wc_q + 8'd1;
                  if (({1'b0, wc_q} + 9'd1) == {1'b0, n_q}) begin
                     state_d = CLOSE;
                  end else begin
                     state_d = STREAM;
                  end
               end
            end else begin
               pend_d = pend_q;
            end
         end
         CLOSE: begin
            send_d    = 1'b1;
            obx_d     = bx_q;
            prev_bx_d = bx_q;
            state_d   = WAIT_HDR;
            if (rd_q) begin
               pend_d      = 1'b1;
               pend_word_d = fifo_dout;
            end else begin
               pend_d = pend_q;
            end
         end
         default: begin
            state_d = WAIT_HDR;
         end
      endcase

      if (hdr_accept_s) begin
         exp_bx_s = chk_bx_s + 4'd1;
         if (!first_q && (in_word_s[3:0] != exp_bx_s)) begin
            seq_d = 1'b1;
         end else begin
            seq_d = 1'b0;
         end
         first_d = 1'b0;
         bx_d    = in_word_s[3:0];
         n_d     = in_word_s[15:8];
         wc_d    = 8'd0;
         if (in_word_s[15:8] == 8'd0) begin
            state_d = CLOSE;
         end else begin
            state_d = STREAM;
         end
      end else begin
         exp_bx_s = 4'd0;
      end
   end

   // State and output registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= WAIT_HDR;
         first_q     <= 1'b1;
         bx_q        <= 4'd0;
         prev_bx_q   <= 4'd0;
         n_q         <= 8'd0;
         wc_q        <= 8'd0;
         rd_q        <= 1'b0;
         pend_q      <= 1'b0;
         pend_word_q <= 48'd0;
         data_q      <= 45'd0;
         valid_q     <= 1'b0;
         obx_q       <= 4'd0;
         send_q      <= 1'b0;
         seq_q       <= 1'b0;
         trunc_q     <= 1'b0;
         drop_q      <= '0;
         orphan_q    <= '0;
      end else begin
         state_q     <= state_d;
         first_q     <= first_d;
         bx_q        <= bx_d;
         prev_bx_q   <= prev_bx_d;
         n_q         <= n_d;
         wc_q        <= wc_d;
         rd_q        <= rd_d;
         pend_q      <= pend_d;
         pend_word_q <= pend_word_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         obx_q       <= obx_d;
         send_q      <= send_d;
         seq_q       <= seq_d;
         trunc_q     <= trunc_d;
         drop_q      <= drop_d;
         orphan_q    <= orphan_d;
      end
   end

endmodule

// File: tb/tb_match_link_rx_framer.sv
// Directed bench for match_link_rx_framer: a memory-backed FIFO model feeds link
// words; a negedge monitor logs valid words, frame closes and error pulses.
module tb_match_link_rx_framer;

   logic        clk = 1'b0;
   logic        reset;
   logic [47:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic        hold;
   logic [44:0] data_residuals;
   logic        valid;
   logic [3:0]  output_BX;
   logic        send_BX;
   logic        err_bx_seq;
   logic        err_trunc;
   logic [15:0] drop_cnt;
   logic [15:0] orphan_cnt;

   always #5 clk = ~clk;

   match_link_rx_framer #(.MAX_WORDS(64), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .hold(hold), .data_residuals(data_residuals),
      .valid(valid), .output_BX(output_BX), .send_BX(send_BX),
      .err_bx_seq(err_bx_seq), .err_trunc(err_trunc),
      .drop_cnt(drop_cnt), .orphan_cnt(orphan_cnt)
   );

   logic [47:0] fmem [0:511];
   int          popc [0:511];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic        force_empty = 1'b0;
   int          cyc = 0;

   assign fifo_empty = force_empty | (wr_ptr == rd_ptr);

   // FIFO model: data appears on fifo_dout the cycle after a pop.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en && !fifo_empty) begin
         fifo_dout    <= fmem[rd_ptr];
         popc[rd_ptr] <= cyc;
         rd_ptr       <= rd_ptr + 1;
      end
   end

   logic [44:0] vword [0:511];
   int          vcyc  [0:511];
   logic [3:0]  sbx   [0:511];
   int          scyc  [0:511];
   int          nv = 0, ns = 0, nseq = 0, ntr = 0;

   // Monitor samples outputs away from the active edge.
   always @(negedge clk) begin
      if (valid && nv < 512) begin
         vword[nv] = data_residuals;
         vcyc[nv]  = cyc;
         nv++;
      end
      if (send_BX && ns < 512) begin
         sbx[ns]  = output_BX;
         scyc[ns] = cyc;
         ns++;
      end
      if (err_bx_seq) nseq++;
      if (err_trunc)  ntr++;
   end

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [47:0] w);
      fmem[wr_ptr] = w;
      wr_ptr++;
   endtask

   function automatic logic [47:0] hdr(input logic [3:0] bx, input logic [7:0] n);
      return {1'b1, 31'd0, n, 4'd0, bx};
   endfunction

   function automatic logic [47:0] dat(input logic [44:0] r);
      return {3'b010, r};
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(1);
   endtask

   int nv0, ns0, nseq0, ntr0, nv_at;

   initial begin
      reset     = 1'b0;
      hold      = 1'b0;
      fifo_dout = 48'd0;

      // Frame 1 is queued while reset holds the block idle.
      push(hdr(4'd3, 8'd4));
      for (int i = 1; i <= 4; i++) push(dat(45'h100_0000_0000 + 45'(i)));
      tick(3);
      check("rst_rd_en",  64'(fifo_rd_en),     64'd0);
      check("rst_data",   64'(data_residuals), 64'd0);
      check("rst_valid",  64'(valid),          64'd0);
      check("rst_obx",    64'(output_BX),      64'd0);
      check("rst_send",   64'(send_BX),        64'd0);
      check("rst_seq",    64'(err_bx_seq),     64'd0);
      check("rst_trunc",  64'(err_trunc),      64'd0);
      check("rst_drop",   64'(drop_cnt),       64'd0);
      check("rst_orphan", 64'(orphan_cnt),     64'd0);
      reset = 1'b1;
      tick(14);
      check("f1_nvalid", 64'(nv), 64'd4);
      for (int i = 0; i < 4; i++)
         check("f1_payload", 64'(vword[i]), 64'h100_0000_0000 + 64'(i + 1));
      check("f1_consec",  64'(vcyc[3] - vcyc[0]), 64'd3);
      check("f1_latency", 64'(vcyc[0] - popc[1]), 64'd2);
      check("f1_nsend",   64'(ns), 64'd1);
      check("f1_sendbx",  64'(sbx[0]), 64'd3);
      check("f1_send_after_valid", 64'(scyc[0] > vcyc[3]), 64'd1);
      check("f1_noseq",   64'(nseq), 64'd0);
      check("f1_notrunc", 64'(ntr),  64'd0);

      // BX wrap 15->0 is in sequence; 0->2 is not.
      do_reset();
      nv0 = nv; ns0 = ns; nseq0 = nseq;
      push(hdr(4'd15, 8'd1)); push(dat(45'h0A));
      push(hdr(4'd0,  8'd1)); push(dat(45'h0B));
      push(hdr(4'd2,  8'd1)); push(dat(45'h0C));
      tick(25);
      check("seq_errs",  64'(nseq - nseq0), 64'd1);
      check("seq_nsend", 64'(ns - ns0), 64'd3);
      check("seq_bx0",   64'(sbx[ns0]),     64'd15);
      check("seq_bx1",   64'(sbx[ns0 + 1]), 64'd0);
      check("seq_bx2",   64'(sbx[ns0 + 2]), 64'd2);
      check("seq_nvalid", 64'(nv - nv0), 64'd3);
      check("seq_order", 64'(vcyc[nv0 + 1] > scyc[ns0]), 64'd1);
      check("seq_pay2",  64'(vword[nv0 + 2]), 64'h0C);

      // N=70 exceeds MAX_WORDS=64: six words dropped.
      nv0 = nv; ns0 = ns; nseq0 = nseq;
      push(hdr(4'd3, 8'd70));
      for (int i = 0; i < 70; i++) push(dat(45'(i + 100)));
      tick(90);
      check("ovf_nvalid", 64'(nv - nv0), 64'd64);
      check("ovf_drop",   64'(drop_cnt), 64'd6);
      check("ovf_nsend",  64'(ns - ns0), 64'd1);
      check("ovf_sendbx", 64'(sbx[ns0]), 64'd3);
      check("ovf_last",   64'(vword[nv0 + 63]), 64'd163);
      check("ovf_noseq",  64'(nseq - nseq0), 64'd0);

      // Truncation: N=5 frame cut after 2 words by header BX=5,N=0.
      nv0 = nv; ns0 = ns; nseq0 = nseq; ntr0 = ntr;
      push(hdr(4'd4, 8'd5)); push(dat(45'h31)); push(dat(45'h32));
      push(hdr(4'd5, 8'd0));
      tick(15);
      check("tr_nvalid", 64'(nv - nv0), 64'd2);
      check("tr_trunc",  64'(ntr - ntr0), 64'd1);
      check("tr_nsend",  64'(ns - ns0), 64'd2);
      check("tr_bx_old", 64'(sbx[ns0]),     64'd4);
      check("tr_bx_new", 64'(sbx[ns0 + 1]), 64'd5);
      check("tr_noseq",  64'(nseq - nseq0), 64'd0);

      // Orphan words before the first header.
      do_reset();
      nv0 = nv; ns0 = ns; nseq0 = nseq;
      push(dat(45'h41)); push(dat(45'h42)); push(dat(45'h43));
      push(hdr(4'd9, 8'd0));
      tick(15);
      check("orph_cnt",    64'(orphan_cnt), 64'd3);
      check("orph_nvalid", 64'(nv - nv0), 64'd0);
      check("orph_nsend",  64'(ns - ns0), 64'd1);
      check("orph_bx",     64'(sbx[ns0]), 64'd9);
      check("orph_noseq",  64'(nseq - nseq0), 64'd0);

      // Backpressure mid-frame with an intermittently empty FIFO.
      nv0 = nv; ns0 = ns; nseq0 = nseq;
      push(hdr(4'd10, 8'd8));
      for (int i = 0; i < 8; i++) push(dat(45'h200 + 45'(i)));
      tick(3);
      hold  = 1'b1;
      nv_at = nv + int'(valid);
      for (int i = 0; i < 10; i++) begin
         force_empty = (i % 2) == 1;
         tick(1);
      end
      check("hold_maxone", 64'((nv - nv_at) <= 1), 64'd1);
      hold = 1'b0;
      for (int i = 0; i < 6; i++) begin
         force_empty = (i % 2) == 0;
         tick(1);
      end
      force_empty = 1'b0;
      tick(20);
      check("hold_nvalid", 64'(nv - nv0), 64'd8);
      for (int i = 0; i < 8; i++)
         check("hold_payload", 64'(vword[nv0 + i]), 64'h200 + 64'(i));
      check("hold_nsend", 64'(ns - ns0), 64'd1);
      check("hold_bx",    64'(sbx[ns0]), 64'd10);
      check("hold_noseq", 64'(nseq - nseq0), 64'd0);

      // Reset abandons a stalled frame; next header is a first frame.
      ns0 = ns; nseq0 = nseq;
      push(hdr(4'd11, 8'd6));
      for (int i = 0; i < 3; i++) push(dat(45'h300 + 45'(i)));
      tick(10);
      reset = 1'b0;
      tick(2);
      check("mrst_valid", 64'(valid),      64'd0);
      check("mrst_send",  64'(send_BX),    64'd0);
      check("mrst_obx",   64'(output_BX),  64'd0);
      check("mrst_data",  64'(data_residuals), 64'd0);
      check("mrst_drop",  64'(drop_cnt),   64'd0);
      check("mrst_orph",  64'(orphan_cnt), 64'd0);
      reset = 1'b1;
      nv0 = nv;
      push(hdr(4'd1, 8'd1)); push(dat(45'h77));
      tick(12);
      check("mrst_nsend",  64'(ns - ns0), 64'd1);
      check("mrst_bx",     64'(sbx[ns0]), 64'd1);
      check("mrst_noseq",  64'(nseq - nseq0), 64'd0);
      check("mrst_nvalid", 64'(nv - nv0), 64'd1);
      check("mrst_pay",    64'(vword[nv0]), 64'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
